// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD adder, LSD first, one digit per clock.
// Define BCD_SERIAL_INVALID_CHECK_EN to build the sticky out_err flag for input digits above 9.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] in_a,
    input  logic [4*DIGITS-1:0] in_b,
    input  logic                in_cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_sum,
    output logic                out_cout,
    output logic                out_err,
    output logic                busy
);
    localparam int W  = 4 * DIGITS;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          carry_q, carry_d;
    logic [3:0]    da, db, dig;
    logic [4:0]    t;
    logic          acc, run;

    assign acc = state_q == IDLE && in_valid;
    assign run = state_q == RUN;
    assign da  = a_q[4*idx_q +: 4];
    assign db  = b_q[4*idx_q +: 4];
    assign t   = {1'b0, da} + {1'b0, db} + {4'd0, carry_q};
    // Subtracting 10 in 4 bits gives (t-10) mod 16 for every t in 10..31.
    assign dig = t > 5'd9 ? t[3:0] - 4'd10 : t[3:0];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = in_a;
                b_d     = in_b;
                carry_d = in_cin;
                idx_d   = '0;
                sum_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = dig;
                carry_d = t > 5'd9;
                idx_d   = idx_q + 1'b1;
                state_d = idx_q == IW'(DIGITS - 1) ? DONE : RUN;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

`ifdef BCD_SERIAL_INVALID_CHECK_EN
    logic err_q, err_d;

    assign err_d = acc ? 1'b0 : err_q | (run && (da > 4'd9 || db > 4'd9));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign out_err = err_q;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = state_q == IDLE && !rst;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign out_sum   = sum_q;
    assign out_cout  = carry_q;
endmodule

// File: doc/bcd_serial_adder.md
# bcd_serial_adder

Digit-serial multi-digit packed-BCD adder that sits directly upstream of the single-digit BCD add stage. It accepts two DIGITS-wide packed BCD operands over a valid/ready handshake and walks them least-significant digit first, one digit per clock. Each digit goes through the standard decimal-correct add, and the carry ripples across cycles. It returns the packed BCD sum and a final carry on a second valid/ready handshake.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand. Legal range is 1..16.
- `clk`  in  1  single clock; rising-edge active.
- `rst`  in  1  asynchronous reset, active-high.
- `in_valid`  in  1  operand offer.
- `in_ready`  out  1  block can accept operands.
- `in_a`  in  4*DIGITS  packed BCD operand A; digit 0 is in bits [3:0].
- `in_b`  in  4*DIGITS  packed BCD operand B.
- `in_cin`  in  1  decimal carry-in to digit 0.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  4*DIGITS  packed BCD sum.
- `out_cout`  out  1  decimal carry out of the top digit.
- `out_err`  out  1  an input digit was greater than 9 (see Configuration).
- `busy`  out  1  high in RUN or DONE.

## Operation
The FSM has three states: IDLE, RUN and DONE.

- **IDLE**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`:
    - latch `in_a`, `in_b` and `in_cin`;
    - set carry to `in_cin`;
    - clear the digit index and the result register;
    - go to RUN.
- **RUN**
  - Each cycle, for digit i, form the 5-bit sum t = a[i] + b[i] + carry.
  - If t > 9: sum digit = (t − 10) mod 16 and carry = 1.
  - Otherwise: sum digit = t[3:0] and carry = 0.
  - Write the sum digit into result digit i and increment i.
  - After digit DIGITS−1 is written, go to DONE.
- **DONE**
  - `out_valid`=1, and `out_sum`/`out_cout`/`out_err` are held stable.
  - On `out_valid`&&`out_ready`, go to IDLE.

Other rules:
- `in_ready` is 1 only in IDLE and while `rst` is low. There is no acceptance in RUN or DONE.
- Input digits greater than 9 are not rejected; they follow the arithmetic rule above. For example, 15+15+1 = 31 gives sum digit 5 and carry 1.
- Outputs are registered. The only exception is `in_ready`, which is decoded from the state.

## Timing
- Reset values: state IDLE; `out_valid`=0, `out_sum`=0, `out_cout`=0, `out_err`=0, `busy`=0.
  - `in_ready`=0 while `rst` is high and 1 in the first cycle after release.
- Latency: operands accepted at edge E0 produce `out_valid`=1 after edge E_DIGITS, i.e. DIGITS cycles later.
- Throughput: one result per DIGITS+2 cycles when `out_ready` is tied high. That is DIGITS RUN cycles, one DONE cycle and one IDLE cycle.
- Backpressure: in DONE with `out_ready`=0, all outputs hold indefinitely. `in_valid` is ignored.
- `in_a`/`in_b`/`in_cin` may change freely after the accept edge; the block uses its latched copies.
- `rst` in RUN or DONE abandons the transaction immediately. No `out_valid` is produced for it, and the next accept can occur in the first cycle after release.
- DIGITS=1: RUN lasts exactly one cycle.

## Configuration
- `BCD_SERIAL_INVALID_CHECK_EN` defined:
  - `out_err` is a sticky flag, cleared on accept.
  - It is set when any processed a[i] or b[i] digit exceeds 9.
  - It is valid with `out_valid`.
  - The sum is still computed by the arithmetic rule.
- `BCD_SERIAL_INVALID_CHECK_EN` not defined: `out_err` is tied to 0 and no check logic is built.

## Test plan
All cases use DIGITS=4 unless noted.

- `in_a`=0x1234, `in_b`=0x5678, `in_cin`=0 -> exactly 4 cycles after accept, `out_sum`=0x6912, `out_cout`=0.
- `in_a`=0x9999, `in_b`=0x0001, `in_cin`=0 -> `out_sum`=0x0000, `out_cout`=1. The carry ripples through all four digits.
- `in_a`=0x0000, `in_b`=0x0000, `in_cin`=1 -> `out_sum`=0x0001, `out_cout`=0.
- Hold `out_ready`=0 for 5 cycles in DONE with 0x4321+0x1111 -> `out_sum`=0x5432 stays stable and `in_ready`=0 throughout. After `out_ready` rises, IDLE follows and the next operands are accepted.
- Assert `rst` 2 cycles into RUN -> `out_valid` never rises for that transaction, and `in_ready`=1 in the cycle after release. Then 0x0005+0x0005 -> `out_sum`=0x0010.
- With the macro defined, 0x00A0+0x0000 -> `out_err`=1 and `out_sum`=0x0100. Without the macro, the same stimulus gives `out_err`=0 with an identical sum.
